// File: rtl/aes_v3_col.sv
// aes_v3_col: multi-cycle AES column SubBytes/MixColumn unit.
// Bytes stream through NSBOX forward/inverse S-box lanes into an accumulator.
module aes_v3_col #(
  parameter int NSBOX     = 1,
  parameter bit GATE_IDLE = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        valid,
  output logic        ready,
  input  logic        dec,
  input  logic        mix,
  input  logic        word,
  input  logic [1:0]  bs,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        rd_valid,
  input  logic        rd_ack,
  output logic [31:0] rd
);

  generate
    if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
      $error("aes_v3_col: NSBOX must be 1, 2 or 4");
    end
  endgenerate

  localparam int         LG    = (NSBOX == 4) ? 2 : (NSBOX == 2) ? 1 : 0;
  localparam logic [1:0] CLAST = 2'(4 / NSBOX - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, with 0 mapping to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] col_vec(input logic [7:0] s,
                                          input logic       d,
                                          input logic       m);
    logic [7:0] s2;
    logic [7:0] s4;
    logic [7:0] s8;
    s2 = xt(s);
    s4 = xt(s2);
    s8 = xt(s4);
    if (!m) return {24'h0, s};
    if (d) return {s8 ^ s2 ^ s, s8 ^ s4 ^ s, s8 ^ s, s8 ^ s4 ^ s2};
    return {s2 ^ s, s, s, s2};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] c,
                                       input logic [1:0]  i);
    case (i)
      2'd0:    return c;
      2'd1:    return {c[23:0], c[31:24]};
      2'd2:    return {c[15:0], c[31:16]};
      default: return {c[7:0], c[31:8]};
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        dec_q, dec_d;
  logic        mix_q, mix_d;
  logic        word_q, word_d;
  logic [1:0]  bs_q, bs_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rd_q, rd_d;

  logic [31:0] contrib;
  logic        last;
  logic [1:0]  lane_idx [NSBOX];
  logic        lane_en  [NSBOX];
  logic [7:0]  sb_in    [NSBOX];
  logic [7:0]  sb_out   [NSBOX];

  // byte mode uses lane 0 only; idle lanes see zero when gated
  always_comb begin
    contrib = 32'h0;
    for (int j = 0; j < NSBOX; j++) begin
      lane_idx[j] = word_q ? ((cnt_q << LG) | 2'(j)) : bs_q;
      lane_en[j]  = (state_q == RUN) && (word_q || j == 0);
      sb_in[j]    = (GATE_IDLE && state_q != RUN) ? 8'h00
                  : rs1_q[8*lane_idx[j] +: 8];
      sb_out[j]   = dec_q ? sbox_inv(sb_in[j]) : sbox_fwd(sb_in[j]);
      if (lane_en[j]) begin
        contrib = contrib
                ^ rotw(col_vec(sb_out[j], dec_q, mix_q), lane_idx[j]);
      end
    end
  end

  assign last = !word_q || (cnt_q == CLAST);

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    mix_d   = mix_q;
    word_d  = word_q;
    bs_d    = bs_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    acc_d   = acc_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          dec_d   = dec;
          mix_d   = mix;
          word_d  = word;
          bs_d    = bs;
          rs1_d   = rs1;
          acc_d   = rs2;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q ^ contrib;
        if (last) begin
          rd_d    = acc_q ^ contrib;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (rd_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q <= IDLE;
      dec_q   <= 1'b0;
      mix_q   <= 1'b0;
      word_q  <= 1'b0;
      bs_q    <= 2'd0;
      cnt_q   <= 2'd0;
      rs1_q   <= 32'h0;
      acc_q   <= 32'h0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      mix_q   <= mix_d;
      word_q  <= word_d;
      bs_q    <= bs_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign rd_valid = (state_q == DONE);
  assign rd       = rd_q;

endmodule

// File: tb/tb_aes_v3_col.sv
// tb_aes_v3_col: vectors, corners and random column ops on NSBOX=1,2,4.
// Reference uses generator-built S-box tables and matrix MixColumns.
module tb_aes_v3_col;

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        rst_i [3];
  logic        valid_i [3];
  logic        dec_i [3], mix_i [3], word_i [3];
  logic [1:0]  bs_i [3];
  logic [31:0] rs1_i [3], rs2_i [3];
  logic        ack_i [3];
  logic        ready_o [3], rdv_o [3];
  logic [31:0] rd_o [3];

  aes_v3_col #(.NSBOX(1), .GATE_IDLE(1'b1)) u_n1 (
    .g_clk(g_clk), .g_rst(rst_i[0]), .valid(valid_i[0]),
    .ready(ready_o[0]), .dec(dec_i[0]), .mix(mix_i[0]),
    .word(word_i[0]), .bs(bs_i[0]), .rs1(rs1_i[0]), .rs2(rs2_i[0]),
    .rd_valid(rdv_o[0]), .rd_ack(ack_i[0]), .rd(rd_o[0]));

  aes_v3_col #(.NSBOX(2), .GATE_IDLE(1'b0)) u_n2 (
    .g_clk(g_clk), .g_rst(rst_i[1]), .valid(valid_i[1]),
    .ready(ready_o[1]), .dec(dec_i[1]), .mix(mix_i[1]),
    .word(word_i[1]), .bs(bs_i[1]), .rs1(rs1_i[1]), .rs2(rs2_i[1]),
    .rd_valid(rdv_o[1]), .rd_ack(ack_i[1]), .rd(rd_o[1]));

  aes_v3_col #(.NSBOX(4), .GATE_IDLE(1'b1)) u_n4 (
    .g_clk(g_clk), .g_rst(rst_i[2]), .valid(valid_i[2]),
    .ready(ready_o[2]), .dec(dec_i[2]), .mix(mix_i[2]),
    .word(word_i[2]), .bs(bs_i[2]), .rs1(rs1_i[2]), .rs2(rs2_i[2]),
    .rd_valid(rdv_o[2]), .rd_ack(ack_i[2]), .rd(rd_o[2]));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] model(input logic d, input logic m,
                                        input logic w, input logic [1:0] b,
                                        input logic [31:0] x,
                                        input logic [31:0] acc);
    logic [7:0]  s [4];
    logic [7:0]  cf [4];
    logic [7:0]  o;
    logic [31:0] res;
    if (d) begin
      cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
    end else begin
      cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
    end
    for (int i = 0; i < 4; i++) begin
      s[i] = d ? isbox[x[8*i +: 8]] : sbox[x[8*i +: 8]];
      if (!w && i != int'(b)) s[i] = 8'h00;
    end
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int c = 0; c < 4; c++) begin
        if (m) o = o ^ gmul(cf[(c - r) & 3], s[c]);
        else if (r == c) o = o ^ s[c];
      end
      res[8*r +: 8] = o;
    end
    return res ^ acc;
  endfunction

  function automatic int exp_lat(input int k, input logic w);
    return w ? 4 / (1 << k) + 1 : 2;
  endfunction

  task automatic run_op(input int k, input logic d, input logic m,
                        input logic w, input logic [1:0] b,
                        input logic [31:0] x, input logic [31:0] acc,
                        output logic [31:0] res);
    int lat;
    @(negedge g_clk);
    check($sformatf("ready pre n%0d", k), 32'(ready_o[k]), 32'h1);
    dec_i[k] = d; mix_i[k] = m; word_i[k] = w; bs_i[k] = b;
    rs1_i[k] = x; rs2_i[k] = acc; valid_i[k] = 1'b1;
    @(negedge g_clk);
    valid_i[k] = 1'b0;
    lat = 1;
    while (rdv_o[k] !== 1'b1 && lat < 20) begin
      @(negedge g_clk);
      lat++;
    end
    check($sformatf("latency n%0d", k), 32'(lat), 32'(exp_lat(k, w)));
    res = rd_o[k];
    ack_i[k] = 1'b1;
    @(negedge g_clk);
    ack_i[k] = 1'b0;
    check($sformatf("ready post ack n%0d", k), 32'(ready_o[k]), 32'h1);
    check($sformatf("rd_valid post ack n%0d", k), 32'(rdv_o[k]), 32'h0);
  endtask

  task automatic sweep(input int k);
    logic [31:0] x, r, e;
    int lat;
    x = $urandom();
    r = $urandom();
    e = model(1'b0, 1'b1, 1'b1, 2'd0, x, r);
    @(negedge g_clk);
    dec_i[k] = 1'b0; mix_i[k] = 1'b1; word_i[k] = 1'b1; bs_i[k] = 2'd0;
    rs1_i[k] = x; rs2_i[k] = r; valid_i[k] = 1'b1;
    @(negedge g_clk);
    lat = 1;
    while (rdv_o[k] !== 1'b1 && lat < 20) begin
      check($sformatf("ready in run n%0d", k), 32'(ready_o[k]), 32'h0);
      valid_i[k] = lat[0];
      rs1_i[k] = ~x;
      rs2_i[k] = 32'h0;
      @(negedge g_clk);
      lat++;
    end
    valid_i[k] = 1'b0;
    check($sformatf("sweep latency n%0d", k), 32'(lat), 32'(exp_lat(k, 1'b1)));
    check($sformatf("sweep rd n%0d", k), rd_o[k], e);
    repeat (10) begin
      @(negedge g_clk);
      check($sformatf("hold rd_valid n%0d", k), 32'(rdv_o[k]), 32'h1);
      check($sformatf("hold rd n%0d", k), rd_o[k], e);
    end
    ack_i[k] = 1'b1;
    @(negedge g_clk);
    ack_i[k] = 1'b0;
    check($sformatf("sweep ready n%0d", k), 32'(ready_o[k]), 32'h1);
    check($sformatf("rd after ack n%0d", k), rd_o[k], e);
    repeat (3) begin
      @(negedge g_clk);
      check($sformatf("no queued req n%0d", k), 32'(rdv_o[k]), 32'h0);
    end
  endtask

  task automatic reset_abort(input int k, input logic in_done);
    int n;
    @(negedge g_clk);
    dec_i[k] = 1'b0; mix_i[k] = 1'b1; word_i[k] = 1'b1; bs_i[k] = 2'd0;
    rs1_i[k] = $urandom(); rs2_i[k] = 32'hdeadbeef; valid_i[k] = 1'b1;
    @(negedge g_clk);
    valid_i[k] = 1'b0;
    n = 1;
    if (in_done) begin
      while (rdv_o[k] !== 1'b1 && n < 20) begin
        @(negedge g_clk);
        n++;
      end
      check($sformatf("reach done n%0d", k), 32'(rdv_o[k]), 32'h1);
    end
    rst_i[k] = 1'b1;
    @(negedge g_clk);
    check($sformatf("abort rd_valid n%0d", k), 32'(rdv_o[k]), 32'h0);
    check($sformatf("abort rd n%0d", k), rd_o[k], 32'h0);
    check($sformatf("abort ready n%0d", k), 32'(ready_o[k]), 32'h1);
    rst_i[k] = 1'b0;
    repeat (6) begin
      @(negedge g_clk);
      check($sformatf("abort quiet n%0d", k), 32'(rdv_o[k]), 32'h0);
    end
  endtask

  task automatic rand_chain(input int k, input logic [31:0] x,
                            input logic [31:0] r, input logic [31:0] e1);
    logic [31:0] res, y, e, x2, r2;
    logic d, m;
    logic [1:0] b;
    run_op(k, 1'b0, 1'b1, 1'b1, 2'd0, x, r, res);
    check($sformatf("enc mix n%0d", k), res, e1);
    y = res;
    run_op(k, 1'b1, 1'b1, 1'b1, 2'd0, y, 32'h0, res);
    check($sformatf("dec mix n%0d", k), res, model(1'b1, 1'b1, 1'b1, 2'd0, y, 32'h0));
    run_op(k, 1'b1, 1'b0, 1'b1, 2'd0, model(1'b0, 1'b0, 1'b1, 2'd0, x, 32'h0),
           32'h0, res);
    check($sformatf("subword round trip n%0d", k), res, x);
    d  = 1'($urandom_range(0, 1));
    m  = 1'($urandom_range(0, 1));
    b  = 2'($urandom_range(0, 3));
    x2 = $urandom();
    r2 = $urandom();
    e  = model(d, m, 1'b0, b, x2, r2);
    run_op(k, d, m, 1'b0, b, x2, r2, res);
    check($sformatf("byte op n%0d", k), res, e);
  endtask

  typedef struct {
    logic        dec;
    logic        mix;
    logic        word;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, x, r, e1;
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b1; valid_i[k] = 1'b0; dec_i[k] = 1'b0;
      mix_i[k] = 1'b0; word_i[k] = 1'b0; bs_i[k] = 2'd0;
      rs1_i[k] = 32'h0; rs2_i[k] = 32'h0; ack_i[k] = 1'b0;
    end
    build_tables();
    vt[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'ha56363c6};
    vt[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'hffffffff, 32'h5a9c9c39};
    vt[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0, 32'h6363c6a5};
    vt[3] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h50a7f451};
    vt[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h000000ed, 32'h0, 32'h00000053};
    vt[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h63636363};
    vt[6] = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h52525252};
    vt[7] = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h63636363};

    repeat (3) @(negedge g_clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ready n%0d", k), 32'(ready_o[k]), 32'h1);
      check($sformatf("reset rd_valid n%0d", k), 32'(rdv_o[k]), 32'h0);
      check($sformatf("reset rd n%0d", k), rd_o[k], 32'h0);
      rst_i[k] = 1'b0;
    end

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 3; k++) begin
        run_op(k, vt[v].dec, vt[v].mix, vt[v].word, vt[v].bs,
               vt[v].rs1, vt[v].rs2, res);
        check($sformatf("vec%0d n%0d", v, k), res, vt[v].exp);
      end
    end

    for (int k = 0; k < 3; k++) begin
      sweep(k);
      reset_abort(k, 1'b0);
      reset_abort(k, 1'b1);
    end

    for (int it = 0; it < 1000; it++) begin
      x  = $urandom();
      r  = $urandom();
      e1 = model(1'b0, 1'b1, 1'b1, 2'd0, x, r);
      fork
        rand_chain(0, x, r, e1);
        rand_chain(1, x, r, e1);
        rand_chain(2, x, r, e1);
      join
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_v3_col.md
# aes_v3_col

Multi-cycle AES column unit that extends the single-byte V3 SubBytes/MixColumn datapath to whole 32-bit columns. It accepts one request per handshake and applies SubBytes or InvSubBytes, with optional MixColumn or InvMixColumn, to either one selected byte or all four bytes of `rs1`. The result is XORed into `rs2`. Bytes pass through a configurable number of S-box instances, so one module serves area-minimal and latency-minimal cores. It sits behind the core's multi-cycle ALU port and returns the result with a valid/ack handshake.

## Interface
- `NSBOX`, default 1: number of S-box instances, each able to do forward and inverse. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `GATE_IDLE`, default 1: when set, S-box inputs are forced to 8'h00 whenever the unit is not in RUN, for logic gating.

Ports:
- `g_clk` in, 1: the single clock.
- `g_rst` in, 1: synchronous, active-high reset.
- `valid` in, 1: request valid.
- `ready` out, 1: the unit can accept a request.
- `dec` in, 1: 0 = encrypt (forward S-box, MixColumn); 1 = decrypt (inverse S-box, InvMixColumn).
- `mix` in, 1: apply the (Inv)MixColumn contribution.
- `word` in, 1: 1 = process all four bytes of `rs1`; 0 = process only byte `bs`.
- `bs` in, 2: byte select. Used only when `word` = 0.
- `rs1` in, 32: source column.
- `rs2` in, 32: accumulator input, XORed into the result.
- `rd_valid` out, 1: result valid.
- `rd_ack` in, 1: result consumed.
- `rd` out, 32: result.

## Operation
- States: IDLE, RUN, DONE. `ready` = (state == IDLE).
- Accept in IDLE when `valid && ready`:
  - latch `dec`, `mix`, `word`, `bs` and `rs1`;
  - load the accumulator with `rs2`;
  - clear the byte counter `cnt`;
  - go to RUN.
- Per-byte contribution for byte index i with S-box output s:
  - build a column vector c, ordered {b3,b2,b1,b0}:
    - encrypt with mix: {3s, s, s, 2s};
    - decrypt with mix: {11s, 13s, 9s, 14s};
    - no mix: {0, 0, 0, s};
  - rotate c left by 8*i bits;
  - XOR the rotated value into the accumulator.
- GF(2^8) arithmetic uses polynomial 0x11b. Products are built with xtime chains, for example 13s = 8s ^ 4s ^ s.
- Word mode:
  - each RUN cycle processes bytes `cnt*NSBOX` through `cnt*NSBOX+NSBOX-1` in parallel;
  - RUN lasts 4/NSBOX cycles, then the unit goes to DONE;
  - the result equals `rs2` ^ (Inv)MixColumns((Inv)SubBytes(column)) when `mix` = 1;
  - the result equals `rs2` ^ (Inv)SubWord(`rs1`) when `mix` = 0.
- Byte mode: RUN lasts exactly 1 cycle and processes byte `bs` on S-box lane 0. All other lanes contribute 0.
- DONE:
  - `rd_valid` = 1 and `rd` = accumulator, both held stable;
  - on `rd_ack` the unit returns to IDLE.
- `valid` is ignored outside IDLE; no request is queued.
- When `rd_valid` = 0, `rd` holds its last value and does not track the accumulator.

## Timing
- Reset values: state IDLE, `ready` = 1, `rd_valid` = 0, `rd` = 32'h0, accumulator = 0, `cnt` = 0.
- Reset in any state, including mid-RUN or DONE with no ack, aborts the operation. No result is produced and the next cycle is IDLE.
- Latency from the accept edge to `rd_valid` = 1:
  - byte mode: 2 cycles;
  - word mode: 4/NSBOX + 1 cycles (5, 3 or 2).
- `rd_ack` asserted in the same cycle `rd_valid` rises counts as consumption. `rd_valid` is 0 and `ready` is 1 in the next cycle.
- The earliest next accept is the cycle after the ack, giving a throughput of one request per latency+1 cycles when `rd_ack` is held at 1.
- `rd_ack` while not in DONE has no effect.
- The S-box and mix paths are combinational within one RUN cycle. Accumulator and `rd` are registered.

## Test plan
- Encrypt, byte mode, mix=1, `bs`=0, `rs1`=0, `rs2`=0 -> `rd`=32'ha56363c6. Repeat with `rs2`=32'hffffffff -> `rd`=32'h5a9c9c39. With `bs`=1 and `rs1`=0 -> `rd`=32'h6363c6a5.
- Decrypt, byte mode, mix=1, `bs`=0, `rs1`=0, `rs2`=0 -> `rd`=32'h50a7f451. Decrypt, mix=0, `rs1`=32'h000000ed -> `rd`=32'h00000053.
- Word mode, encrypt, mix=0, `rs1`=0 -> 32'h63636363. Decrypt, mix=0, `rs1`=0 -> 32'h52525252. Encrypt, mix=1, `rs1`=0 -> 32'h63636363.
- Latency sweep for NSBOX = 1, 2, 4 in word mode:
  - `rd_valid` rises 5, 3 and 2 cycles after accept respectively;
  - `ready` = 0 throughout;
  - `valid` pulses during RUN are ignored.
- Round trip: for 1000 random `rs1` values, the word-mode encrypt-with-mix result fed to a decrypt path reproduces the AES reference column model, and the results are bit-identical across all NSBOX values.
- Reset and ack corners:
  - `g_rst` mid-RUN gives `rd_valid`=0, `rd`=0, `ready`=1 the next cycle;
  - `rd_ack` in the same cycle as `rd_valid` rises gives `ready`=1 the next cycle;
  - holding DONE for 10 cycles without ack keeps `rd` stable.
